// File: rtl/jtgng_loader_pkg.sv
// Shared definitions for the PROM download loader: FSM states and the
// download address width.
package jtgng_loader_pkg;

    localparam int DL_AW = 22;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/jtgng_prom_decode.sv
// Combinational decode of a download byte address into a region hit,
// a region-relative index and a one-hot PROM select.
module jtgng_prom_decode
    import jtgng_loader_pkg::*;
#(
    parameter int               AW         = 8,
    parameter int               NPROM      = 8,
    parameter logic [DL_AW-1:0] PROM_START = 22'h1_8000
) (
    input  logic [DL_AW-1:0] addr_i,
    output logic             in_region_o,
    output logic [AW+4:0]    index_o,
    output logic [NPROM-1:0] sel_o
);

    localparam logic [DL_AW-1:0] REGION_LEN = DL_AW'(NPROM) << AW;

    logic [DL_AW-1:0] offset;
    logic [3:0]       prom_idx;

    // Below-start addresses wrap to huge offsets, so one compare covers both ends.
    assign offset      = addr_i - PROM_START;
    assign in_region_o = (addr_i >= PROM_START) && (offset < REGION_LEN);
    assign index_o     = offset[AW+4:0];
    assign prom_idx    = offset[AW+3:AW];

    generate
        for (genvar gi = 0; gi < NPROM; gi++) begin : g_sel
            assign sel_o[gi] = in_region_o && (prom_idx == 4'(gi));
        end
    endgenerate

endmodule

// File: rtl/jtgng_prom_loader.sv
// Routes a byte-serial download into NPROM small PROMs and tracks ordering.
// Optional byte checksum on prom_sum is enabled with JTGNG_PROM_LOADER_SUM_EN.
module jtgng_prom_loader
    import jtgng_loader_pkg::*;
#(
    parameter int               DW         = 4,
    parameter int               AW         = 8,
    parameter int               NPROM      = 8,
    parameter logic [DL_AW-1:0] PROM_START = 22'h1_8000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ioctl_downloading,
    input  logic             ioctl_wr,
    input  logic [21:0]      ioctl_addr,
    input  logic [7:0]       ioctl_data,
    output logic [NPROM-1:0] prom_we,
    output logic [AW-1:0]    prom_addr,
    output logic [DW-1:0]    prom_data,
    output logic             loaded,
    output logic             seq_err,
    output logic [7:0]       prom_sum
);

    localparam int            CW    = AW + 5;
    localparam logic [CW-1:0] TOTAL = CW'(NPROM) << AW;

    state_t           state_q, state_d;
    logic             dl_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             loaded_q, loaded_d;
    logic [NPROM-1:0] we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    data_q, data_d;

    logic             in_region;
    logic [CW-1:0]    index;
    logic [NPROM-1:0] sel;
    logic             rise, fall, wr_ok, load_entry;

    jtgng_prom_decode #(
        .AW         (AW),
        .NPROM      (NPROM),
        .PROM_START (PROM_START)
    ) u_decode (
        .addr_i      (ioctl_addr),
        .in_region_o (in_region),
        .index_o     (index),
        .sel_o       (sel)
    );

    assign rise       = ioctl_downloading && !dl_q;
    assign fall       = !ioctl_downloading && dl_q;
    assign wr_ok      = (state_q == LOAD) && ioctl_wr && in_region;
    assign load_entry = (state_q != LOAD) && rise;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        loaded_d = loaded_q;
        we_d     = '0;
        addr_d   = addr_q;
        data_d   = data_q;
        case (state_q)
            IDLE, DONE: begin
                if (rise) begin
                    state_d  = LOAD;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    loaded_d = 1'b0;
                end
            end
            LOAD: begin
                if (wr_ok) begin
                    we_d   = sel;
                    addr_d = index[AW-1:0];
                    data_d = ioctl_data[DW-1:0];
                    if (index == cnt_q) begin
                        cnt_d = (cnt_q == TOTAL) ? TOTAL : cnt_q + CW'(1);
                    end else begin
                        err_d = 1'b1;
                        cnt_d = index + CW'(1);
                    end
                end
                // Judged on the next-state values so a write on the falling cycle counts.
                if (fall) begin
                    state_d  = DONE;
                    loaded_d = (cnt_d == TOTAL) && !err_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // dl_q resets high so a download still active when reset releases is not
    // mistaken for a fresh session start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dl_q     <= 1'b1;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
            we_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            dl_q     <= ioctl_downloading;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

`ifdef JTGNG_PROM_LOADER_SUM_EN
    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (load_entry) begin
            sum_d = '0;
        end else if (wr_ok) begin
            sum_d = sum_q + ioctl_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign prom_sum = sum_q;
`else
    logic unused_sum_inputs;
    assign unused_sum_inputs = load_entry ^ (^ioctl_data);
    assign prom_sum = '0;
`endif

    assign prom_we   = we_q;
    assign prom_addr = addr_q;
    assign prom_data = data_q;
    assign loaded    = loaded_q;
    assign seq_err   = err_q;

endmodule

// File: tb/tb_jtgng_prom_loader.sv
// Directed testbench for jtgng_prom_loader with default parameters.
module tb_jtgng_prom_loader;

    localparam int NPROM = 8;
`ifdef JTGNG_PROM_LOADER_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             dl = 1'b0;
    logic             wr = 1'b0;
    logic [21:0]      addr = '0;
    logic [7:0]       data = '0;
    logic [NPROM-1:0] prom_we;
    logic [7:0]       prom_addr;
    logic [3:0]       prom_data;
    logic             loaded;
    logic             seq_err;
    logic [7:0]       prom_sum;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_sum;

    always #5 clk = ~clk;

    jtgng_prom_loader dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ioctl_downloading (dl),
        .ioctl_wr          (wr),
        .ioctl_addr        (addr),
        .ioctl_data        (data),
        .prom_we           (prom_we),
        .prom_addr         (prom_addr),
        .prom_data         (prom_data),
        .loaded            (loaded),
        .seq_err           (seq_err),
        .prom_sum          (prom_sum)
    );

    task automatic test_reset();
        rst_n = 1'b0; dl = 1'b0; wr = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (prom_we !== 8'h00) begin fails++; $display("FAIL reset_we got=%h exp=00", prom_we); end
        tests++; if (prom_addr !== 8'h00) begin fails++; $display("FAIL reset_addr got=%h exp=00", prom_addr); end
        tests++; if (prom_data !== 4'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", prom_data); end
        tests++; if ({loaded, seq_err} !== 2'b00) begin fails++; $display("FAIL reset_flags got=%b exp=00", {loaded, seq_err}); end
        tests++; if (prom_sum !== 8'h00) begin fails++; $display("FAIL reset_sum got=%h exp=00", prom_sum); end
        rst_n = 1'b1;
        // Write before any session: must be ignored.
        @(negedge clk); wr = 1'b1; addr = 22'h1_8000; data = 8'h9C;
        @(negedge clk); wr = 1'b0;
        tests++; if (prom_we !== 8'h00) begin fails++; $display("FAIL idle_write_we got=%h exp=00", prom_we); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); dl = 1'b1; wr = 1'b0;
        exp_sum = 8'h00;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tests++; if (prom_we !== 8'h00) begin fails++; $display("FAIL b2b_early_we got=%h exp=00", prom_we); end
            end else begin
                tests++;
                if (prom_we !== 8'h01 || prom_addr !== 8'(k - 1)) begin
                    fails++; $display("FAIL b2b_pulse%0d got we=%h addr=%h exp we=01 addr=%h", k - 1, prom_we, prom_addr, 8'(k - 1));
                end
            end
            wr = 1'b1; addr = 22'h1_8000 + 22'(k); data = 8'h50 + 8'(k);
            exp_sum = exp_sum + data;
        end
        @(negedge clk); wr = 1'b0;
        tests++;
        if (prom_we !== 8'h01 || prom_addr !== 8'h03 || prom_data !== 4'h3) begin
            fails++; $display("FAIL b2b_pulse3 got we=%h addr=%h data=%h exp we=01 addr=03 data=3", prom_we, prom_addr, prom_data);
        end
        @(negedge clk);
        tests++;
        if (prom_we !== 8'h00 || prom_addr !== 8'h03 || prom_data !== 4'h3) begin
            fails++; $display("FAIL b2b_hold got we=%h addr=%h data=%h exp we=00 addr=03 data=3", prom_we, prom_addr, prom_data);
        end
        dl = 1'b0;
        @(negedge clk);
        tests++; if ({loaded, seq_err} !== 2'b00) begin fails++; $display("FAIL b2b_flags got=%b exp=00", {loaded, seq_err}); end
        tests++; if (prom_sum !== (SUM_EN ? exp_sum : 8'h00)) begin fails++; $display("FAIL b2b_sum got=%h exp=%h", prom_sum, SUM_EN ? exp_sum : 8'h00); end
    endtask

    task automatic test_out_of_region();
        logic [21:0]      a_tab [4];
        logic [7:0]       d_tab [4];
        logic [NPROM-1:0] w_tab [4];
        a_tab = '{22'h1_8000, 22'h1_7FFF, 22'h1_8800, 22'h1_8001};
        d_tab = '{8'hA5, 8'h11, 8'h22, 8'h3C};
        w_tab = '{8'h01, 8'h00, 8'h00, 8'h01};
        @(negedge clk); dl = 1'b1; wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                tests++; if (prom_we !== w_tab[i-1]) begin fails++; $display("FAIL oor_we%0d got=%h exp=%h", i - 1, prom_we, w_tab[i-1]); end
            end
            wr = 1'b1; addr = a_tab[i]; data = d_tab[i];
        end
        @(negedge clk); wr = 1'b0; dl = 1'b0;
        tests++; if (prom_we !== 8'h01 || prom_addr !== 8'h01) begin fails++; $display("FAIL oor_last got we=%h addr=%h exp we=01 addr=01", prom_we, prom_addr); end
        tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL oor_seq_err got=%b exp=0", seq_err); end
        @(negedge clk);
        tests++; if (prom_sum !== (SUM_EN ? 8'hE1 : 8'h00)) begin fails++; $display("FAIL oor_sum got=%h exp=%h", prom_sum, SUM_EN ? 8'hE1 : 8'h00); end
        // In DONE: write must be ignored entirely.
        wr = 1'b1; addr = 22'h1_8002; data = 8'h77;
        @(negedge clk); wr = 1'b0;
        tests++; if (prom_we !== 8'h00 || prom_addr !== 8'h01) begin fails++; $display("FAIL done_write got we=%h addr=%h exp we=00 addr=01", prom_we, prom_addr); end
        tests++; if (prom_sum !== (SUM_EN ? 8'hE1 : 8'h00)) begin fails++; $display("FAIL done_sum got=%h exp=%h", prom_sum, SUM_EN ? 8'hE1 : 8'h00); end
    endtask

    task automatic test_seq_gap();
        int prev;
        prev = -1;
        @(negedge clk); dl = 1'b1; wr = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            if (i == 'h100) continue;
            @(negedge clk);
            if (prev == 'hFF) begin
                tests++; if (seq_err !== 1'b0) begin fails++; $display("FAIL gap_pre_err got=%b exp=0", seq_err); end
            end
            if (prev == 'h101) begin
                tests++;
                if (prom_we !== 8'h02 || prom_addr !== 8'h01 || seq_err !== 1'b1) begin
                    fails++; $display("FAIL gap_write got we=%h addr=%h err=%b exp we=02 addr=01 err=1", prom_we, prom_addr, seq_err);
                end
            end
            wr = 1'b1; addr = 22'h1_8000 + 22'(i); data = 8'(i);
            prev = i;
        end
        @(negedge clk); wr = 1'b0; dl = 1'b0;
        @(negedge clk);
        tests++; if ({loaded, seq_err} !== 2'b01) begin fails++; $display("FAIL gap_end got loaded,err=%b exp=01", {loaded, seq_err}); end
    endtask

    task automatic test_second_session();
        @(negedge clk); dl = 1'b1; wr = 1'b0;
        @(negedge clk);
        tests++; if ({loaded, seq_err} !== 2'b00) begin fails++; $display("FAIL entry_flags got=%b exp=00", {loaded, seq_err}); end
        tests++; if (prom_sum !== 8'h00) begin fails++; $display("FAIL entry_sum got=%h exp=00", prom_sum); end
        exp_sum = 8'h00;
        for (int i = 0; i < 2048; i++) begin
            if (i > 0) begin
                @(negedge clk);
                tests++;
                if (prom_we !== 8'(1 << ((i - 1) >> 8)) || prom_addr !== 8'(i - 1) || prom_data !== 4'(i - 1)) begin
                    fails++; $display("FAIL full_byte%0d got we=%h addr=%h data=%h exp we=%h addr=%h data=%h", i - 1,
                                      prom_we, prom_addr, prom_data, 8'(1 << ((i - 1) >> 8)), 8'(i - 1), 4'(i - 1));
                end
            end
            wr = 1'b1; addr = 22'h1_8000 + 22'(i); data = 8'(i);
            exp_sum = exp_sum + data;
            // Final byte lands on the same cycle the session ends.
            if (i == 2047) dl = 1'b0;
        end
        @(negedge clk); wr = 1'b0;
        tests++; if (prom_we !== 8'h80 || prom_addr !== 8'hFF || prom_data !== 4'hF) begin fails++; $display("FAIL full_last got we=%h addr=%h data=%h exp we=80 addr=ff data=f", prom_we, prom_addr, prom_data); end
        tests++; if ({loaded, seq_err} !== 2'b10) begin fails++; $display("FAIL full_flags got loaded,err=%b exp=10", {loaded, seq_err}); end
        tests++; if (prom_sum !== (SUM_EN ? exp_sum : 8'h00)) begin fails++; $display("FAIL full_sum got=%h exp=%h", prom_sum, SUM_EN ? exp_sum : 8'h00); end
        @(negedge clk);
        tests++; if (prom_we !== 8'h00 || loaded !== 1'b1) begin fails++; $display("FAIL full_after got we=%h loaded=%b exp we=00 loaded=1", prom_we, loaded); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); dl = 1'b1; wr = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); wr = 1'b1; addr = 22'h1_8000 + 22'(i); data = 8'(i + 7);
        end
        @(negedge clk); wr = 1'b0;
        tests++; if (prom_we !== 8'h02 || prom_addr !== 8'hF3) begin fails++; $display("FAIL mid_pre got we=%h addr=%h exp we=02 addr=f3", prom_we, prom_addr); end
        rst_n = 1'b0;
        #1;
        tests++;
        if (prom_we !== 8'h00 || prom_addr !== 8'h00 || prom_data !== 4'h0 || loaded !== 1'b0 || seq_err !== 1'b0 || prom_sum !== 8'h00) begin
            fails++; $display("FAIL mid_async got we=%h addr=%h data=%h ld=%b err=%b sum=%h exp all zero", prom_we, prom_addr, prom_data, loaded, seq_err, prom_sum);
        end
        @(negedge clk);
        tests++;
        if (prom_we !== 8'h00 || prom_addr !== 8'h00 || prom_data !== 4'h0 || loaded !== 1'b0 || seq_err !== 1'b0 || prom_sum !== 8'h00) begin
            fails++; $display("FAIL mid_held got we=%h addr=%h data=%h ld=%b err=%b sum=%h exp all zero", prom_we, prom_addr, prom_data, loaded, seq_err, prom_sum);
        end
        rst_n = 1'b1;
        // Download still high after release: no session until a new rising edge.
        @(negedge clk); wr = 1'b1; addr = 22'h1_8000; data = 8'h12;
        @(negedge clk); wr = 1'b0;
        tests++; if (prom_we !== 8'h00) begin fails++; $display("FAIL mid_no_session got we=%h exp=00", prom_we); end
        dl = 1'b0;
        @(negedge clk); dl = 1'b1;
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk); wr = 1'b1; addr = 22'h1_8000 + 22'(i); data = 8'(i);
        end
        @(negedge clk); wr = 1'b0; dl = 1'b0;
        @(negedge clk);
        tests++; if ({loaded, seq_err} !== 2'b10) begin fails++; $display("FAIL mid_reload got loaded,err=%b exp=10", {loaded, seq_err}); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_out_of_region();
        test_seq_gap();
        test_second_session();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
